// File: rtl/pip_norm_pack.sv
// pip_norm_pack: two-stage signed-sum to FP16/FP32 normalise, round-to-nearest-even and pack.
// Define PACK_SUBNORM_EN to produce subnormal results instead of flushing them to signed zero.
module pip_norm_pack #(
  parameter int SUM_W   = 32,
  parameter int FRAC_W  = 20,
  parameter int EXP_W   = 10,
  parameter int EXP_OFS = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode_sel,
  input  logic [SUM_W-1:0] i_sum,
  input  logic [EXP_W-1:0] i_exp_max,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic             o_mode_err
);
  localparam int MW = SUM_W + 1;
  localparam int PW = $clog2(MW);
  logic adv, a_valid, a_sign, a_fp32;
  logic [MW-1:0] a_mag, sx;
  logic signed [EXP_W+1:0] a_e;
  logic [MW-2:0] norm, sig;
  logic [PW-1:0] p;
  logic signed [15:0] eb;
  logic lost, g, s, inc, ovf, low;
  logic [22:0] man;
  logic [7:0] ef;
  logic [31:0] res;
`ifdef PACK_SUBNORM_EN
  logic [6:0] sh;
`endif
  assign adv = !o_valid | i_ready;
  assign o_ready = adv | !a_valid;
  assign sx = {i_sum[SUM_W-1], i_sum};
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      o_valid <= 1'b0;
      o_result <= '0;
      o_mode_err <= 1'b0;
    end else begin
      if (o_ready) begin
        a_valid <= i_valid & !i_mode_sel[1];
        a_sign <= i_sum[SUM_W-1];
        a_mag <= i_sum[SUM_W-1] ? -sx : sx;
        a_e <= $signed({2'b00, i_exp_max}) - (EXP_W+2)'(EXP_OFS);
        a_fp32 <= i_mode_sel[0];
      end
      if (i_valid & o_ready & (i_mode_sel == 2'b10)) o_mode_err <= 1'b1;
      if (adv) begin
        o_valid <= a_valid;
        if (a_valid) o_result <= res;
      end
    end
  end
  // norm holds the fraction bits below the leading one, MSB-aligned
  always_comb begin
    p = '0;
    for (int i = 0; i < MW; i++) if (a_mag[i]) p = PW'(i);
    norm = (MW-1)'(a_mag << (PW'(MW-1) - p));
    eb = 16'(a_e) + 16'(p) - 16'(FRAC_W) + (a_fp32 ? 16'sd127 : 16'sd15);
    low = eb <= 16'sd0;
    ovf = eb >= (a_fp32 ? 16'sd255 : 16'sd31);
`ifdef PACK_SUBNORM_EN
    sh = low ? (((16'sd1 - eb) > 16'sd34) ? 7'd34 : 7'(16'sd1 - eb)) : 7'd0;
    sig = (MW-1)'({1'b1, norm} >> sh);
    lost = |({1'b1, norm} & ~({MW{1'b1}} << sh));
`else
    sig = norm;
    lost = 1'b0;
`endif
    man = a_fp32 ? sig[MW-2 -: 23] : {13'd0, sig[MW-2 -: 10]};
    g = a_fp32 ? sig[MW-25] : sig[MW-12];
    s = lost | (a_fp32 ? |sig[MW-26:0] : |sig[MW-13:0]);
    inc = g & (s | man[0]);
    ef = low ? 8'd0 : eb[7:0];
    // the +inc carry ripples into the exponent field, covering mantissa overflow and min-normal
    res = a_fp32 ? {a_sign, {ef, man} + 31'(inc)} : {16'd0, a_sign, {ef[4:0], man[9:0]} + 15'(inc)};
    if (a_mag == '0) res = '0;
    else if (ovf) res = a_fp32 ? {a_sign, 8'hFF, 23'd0} : {16'd0, a_sign, 5'h1F, 10'd0};
`ifndef PACK_SUBNORM_EN
    else if (low) res = a_fp32 ? {a_sign, 31'd0} : {16'd0, a_sign, 15'd0};
`endif
  end
endmodule

// File: tb/tb_pip_norm_pack.sv
// tb_pip_norm_pack: randomized scoreboard bench for pip_norm_pack with directed literal vectors.
module tb_pip_norm_pack;
  logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_ready = 1'b1;
  logic o_ready, o_valid, o_mode_err;
  logic [1:0] i_mode_sel = 2'b11;
  logic [31:0] i_sum = '0, o_result;
  logic [9:0] i_exp_max = '0;
  int checks = 0, errors = 0, rdy_mode = 0, pc = 0;
  logic [31:0] exp_q[$], got_q[$];
  logic [31:0] held, ev;
  logic err_m = 1'b0, stall = 1'b0;
  logic [31:0] f5 [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                          32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  always #5 clk = ~clk;

  pip_norm_pack dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode_sel(i_mode_sel),
    .i_sum(i_sum), .i_exp_max(i_exp_max), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_mode_err(o_mode_err)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // value = |sum| * 2^(exp-50); round that to the target grid directly
  function automatic logic [31:0] model(logic [31:0] sum, logic [9:0] ex, bit fp32);
    int m = fp32 ? 23 : 10;
    int b = fp32 ? 127 : 15;
    int emax = fp32 ? 255 : 31;
    int e = int'(ex) - 50;
    bit sg = sum[31];
    longint mag = sg ? -longint'($signed(sum)) : longint'(sum);
    longint n, r, half;
    int lg = 0, q, k, ef;
    logic [31:0] inf = fp32 ? {sg, 8'hFF, 23'd0} : {16'd0, sg, 5'h1F, 10'd0};
    if (mag == 0) return 32'd0;
    while ((mag >> (lg + 1)) != 0) lg++;
    if (lg + e + b >= emax) return inf;
`ifdef PACK_SUBNORM_EN
    q = ((lg + e > 1 - b) ? lg + e : 1 - b) - m;
`else
    if (lg + e + b <= 0) return fp32 ? {sg, 31'd0} : {16'd0, sg, 15'd0};
    q = lg + e - m;
`endif
    k = e - q;
    if (k >= 0) n = mag << k;
    else if (-k > 40) n = 0;
    else begin
      n = mag >> -k;
      r = mag - (n << -k);
      half = 64'sd1 << (-k - 1);
      if (r > half || (r == half && n[0])) n++;
    end
    if (n >= (64'sd1 << (m + 1))) begin n = n >> 1; q++; end
    if (n < (64'sd1 << m)) ef = 0;
    else begin
      ef = q + m + b;
      n = n - (64'sd1 << m);
      if (ef >= emax) return inf;
    end
    return fp32 ? {sg, 8'(ef), 23'(n)} : {16'd0, sg, 5'(ef), 10'(n)};
  endfunction

  initial forever begin
    @(posedge clk); #1;
    i_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (pc % 3 == 0);
    pc++;
  end

  always @(negedge clk) begin
    check("mode_err", 32'(o_mode_err), 32'(err_m));
    if (stall) begin
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_result", o_result, held);
    end
    if (rst) begin
      exp_q.delete();
      err_m = 1'b0;
      stall = 1'b0;
    end else begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_output: got %h, expected no output at %0t", o_result, $time);
        end else begin
          ev = exp_q.pop_front();
          check("result", o_result, ev);
          got_q.push_back(o_result);
        end
      end
      if (i_valid && o_ready) begin
        if (i_mode_sel == 2'b10) err_m = 1'b1;
        else if (i_mode_sel != 2'b11) exp_q.push_back(model(i_sum, i_exp_max, i_mode_sel[0]));
      end
      stall = o_valid && !i_ready;
      held = o_result;
    end
  end

  task automatic send(logic [31:0] s, logic [9:0] x, logic [1:0] m);
    int n = 0;
    logic acc;
    i_valid = 1'b1; i_sum = s; i_exp_max = x; i_mode_sel = m;
    do begin
      @(negedge clk); acc = o_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 100);
    check("send_accept", 32'(acc), 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    i_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic lat(string name, logic [31:0] s, logic [9:0] x, logic [1:0] m, logic [31:0] lit);
    check({name, "_model"}, model(s, x, m[0]), lit);
    send(s, x, m);
    check({name, "_early"}, 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(o_valid), 32'd1);
    check(name, o_result, lit);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] s;
    logic [9:0] x;
    int r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_err", 32'(o_mode_err), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    lat("one_fp16", 32'h0010_0000, 10'd30, 2'b00, 32'h0000_3C00);
    lat("one_fp32", 32'h0010_0000, 10'd30, 2'b01, 32'h3F80_0000);
    lat("neg_fp16", -(32'd3 << 19), 10'd30, 2'b00, 32'h0000_BE00);
    lat("zero_fp32", 32'd0, 10'd30, 2'b01, 32'h0000_0000);
    lat("most_neg", 32'h8000_0000, 10'd30, 2'b01, 32'hC500_0000);
    lat("rne_tie", 32'h0010_0200, 10'd30, 2'b00, 32'h0000_3C00);
    lat("rne_up", 32'h0010_0600, 10'd30, 2'b00, 32'h0000_3C02);
    lat("rne_carry", 32'h001F_FF00, 10'd30, 2'b00, 32'h0000_4000);
    lat("ovf_inf", 32'h0010_0000, 10'd46, 2'b00, 32'h0000_7C00);
    lat("deep_under", 32'h0010_0000, 10'd5, 2'b00, 32'h0000_0000);
    lat("min_normal", 32'h0010_0000, 10'd16, 2'b00, 32'h0000_0400);
`ifdef PACK_SUBNORM_EN
    lat("subnormal", 32'h0010_0000, 10'd15, 2'b00, 32'h0000_0200);
`else
    lat("flush", 32'h0010_0000, 10'd15, 2'b00, 32'h0000_0000);
`endif
    drain();
    got_q.delete();
    rdy_mode = 2;
    for (int k = 1; k <= 8; k++) send(32'(k) << 20, 10'd30, 2'b01);
    drain();
    check("bp_count", 32'(got_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < got_q.size(); k++) check("bp_value", got_q[k], f5[k]);
    rdy_mode = 0;
    send(32'h0010_0000, 10'd30, 2'b11);
    send(32'h0020_0000, 10'd30, 2'b00);
    check("err_before", 32'(o_mode_err), 32'd0);
    send(32'h0030_0000, 10'd30, 2'b10);
    check("err_set", 32'(o_mode_err), 32'd1);
    send(32'h0040_0000, 10'd30, 2'b01);
    send(32'h0050_0000, 10'd30, 2'b11);
    drain();
    check("err_sticky", 32'(o_mode_err), 32'd1);
    rdy_mode = 2;
    for (int k = 1; k <= 3; k++) send(32'(k) << 20, 10'd30, 2'b00);
    i_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_err", 32'(o_mode_err), 32'd0);
    check("midrst_result", o_result, 32'd0);
    rst = 1'b0; i_valid = 1'b0;
    rdy_mode = 1;
    for (int t = 0; t < 600; t++) begin
      r = $urandom_range(0, 3);
      s = (r == 0) ? $urandom : (r == 1) ? 32'($urandom_range(0, 255)) :
          (r == 2) ? ((32'd1 << $urandom_range(0, 30)) | 32'($urandom_range(0, 15))) :
          -(32'($urandom_range(1, 1 << 22)));
      x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 60));
      r = $urandom_range(0, 19);
      send(s, x, (r < 8) ? 2'b00 : (r < 16) ? 2'b01 : (r < 17) ? 2'b10 : 2'b11);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rdy_mode = 0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
